debouncer: RTL and testbench
============================

// Module: debouncer
// PURPOSE
//   Debounces and synchronizes a raw, asynchronous mechanical input such as a pushbutton.
//   - Two-flop synchronizer feeds a stability counter.
//   - Out follows the synchronized input only after it has differed from Out for 2^Width
//     consecutive enabled cycles.
//   - In the top level it cleans GPIO_SW_C into the system reset request (Width=20 at 10 MHz).
// PARAMETERS
//   Width  20  stability counter width (>=1); required stable time = 2^Width enabled cycles
// PORTS
//   Clock   in   1  single clock; all state updates on the rising edge
//   Reset   in   1  synchronous, active-high reset
//   Enable  in   1  count qualifier (clock-enable tick); low freezes the counter
//   In      in   1  raw asynchronous input
//   Out     out  1  debounced level, registered
//   Rise    out  1  one-cycle pulse, high in the first cycle Out reads 1; may be left unconnected
//   Fall    out  1  one-cycle pulse, high in the first cycle Out reads 0; may be left unconnected
// BEHAVIOUR
//   - Reset (sampled on a Clock edge while Reset=1):
//     - sync0, sync1, cnt, Out, Rise and Fall all clear to 0.
//     - Reset overrides Enable and In.
//   - Synchronizer, every edge while not in reset:
//     - sync0<=In; sync1<=sync0.
//     - Only sync1 (s) is used downstream; In itself is never used combinationally.
//   - Counter: cnt[Width-1:0], MAX = 2^Width-1. Per edge, not in reset, in priority order:
//     1. s==Out: cnt<=0. Any bounce restarts the stability window.
//     2. s!=Out, Enable=0: cnt holds; Out holds.
//     3. s!=Out, Enable=1, cnt!=MAX: cnt<=cnt+1.
//     4. s!=Out, Enable=1, cnt==MAX: Out<=s, cnt<=0.
//   - Latency (Enable tied high):
//     - Out changes exactly 2^Width+2 edges after the edge that first samples the new In level.
//     - 2 edges are spent in the synchronizer and 2^Width edges in counting.
//     - With Enable gated, only enabled cycles count toward the 2^Width.
//   - Rise/Fall are registered on the edge where Out updates:
//     - Rise<=(Out==0 && s==1 && update), Fall<=(Out==1 && s==0 && update).
//     - Both are 0 on every other edge.
//     - Never both high at once; never high two cycles in a row.
//   - Glitches: an input pulse (at s) shorter than 2^Width enabled cycles never reaches Out
//     and produces no Rise/Fall.
//   - Counter width: cnt never wraps. It is cleared at MAX on update, and cleared whenever s==Out.
//   - Reset mid-count: the count is discarded. After Reset deasserts, a full 2^Width+2 cycle
//     latency applies again, measured from the synchronizer refilling.
//   - In held high through reset: Out rises 2^Width+2 edges after the first non-reset edge.
// TESTING  (use Width=4 -> 16 enabled cycles; Enable=1 unless stated)
//   - Reset, then In 0->1 held:
//     - Out=0, Rise=0 for 17 edges after the change is sampled.
//     - Out=1 and Rise=1 at edge 18; Rise=0 at edge 19.
//   - Glitch rejection:
//     - In=1 for 10 cycles then back to 0 -> Out stays 0, Rise/Fall never assert.
//     - Bounce In 1/0 every 3 cycles for 100 cycles, then hold 1 -> Out rises 18 edges after the final hold begins.
//   - Enable gating:
//     - Enable pulses high 1 cycle in 4, In=1 -> Out rises after 16 enabled edges plus the 2 sync edges.
//     - Holding Enable=0 keeps Out=0 indefinitely.
//   - Release: from Out=1, drive In=0 -> Fall pulses for exactly one cycle when Out drops, 18 edges later.
//   - Reset mid-count:
//     - Assert Reset 1 cycle while cnt=10 -> Out=0, cnt=0.
//     - With In still 1 after release, Out rises 18 edges after the first non-reset edge.
//   - Reset while Out=1 -> Out=0, Rise=0, Fall=0 on the next edge; no Fall pulse is generated by reset.

Source files
------------

// File: rtl/debouncer.sv
// ---------------------------------------------------------------------------
// debouncer
//
// Purpose:
//   Cleans up a raw, asynchronous mechanical input such as a pushbutton.
//   The input first passes through a two-flop synchronizer. A stability
//   counter then lets the debounced level follow the synchronized input only
//   after the two have disagreed for 2^Width consecutive enabled cycles. Any
//   bounce back to the current output level restarts the stability window.
//   In the top level this cleans GPIO_SW_C into the system reset request
//   (Width=20 at 10 MHz gives roughly 105 ms of required stability).
//
// Parameters:
//   Width   stability counter width (>= 1); stable time = 2^Width enabled cycles
//
// Ports:
//   Clock   in   single clock, all state updates on the rising edge
//   Reset   in   synchronous, active-high reset; overrides Enable and In
//   Enable  in   count qualifier (clock-enable tick); low freezes the counter
//   In      in   raw asynchronous input, only ever seen through the synchronizer
//   Out     out  debounced level, registered
//   Rise    out  one-cycle pulse in the first cycle Out reads 1
//   Fall    out  one-cycle pulse in the first cycle Out reads 0
// ---------------------------------------------------------------------------
module debouncer #(
  parameter int Width = 20
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  input  logic In,
  output logic Out,
  output logic Rise,
  output logic Fall
);

  localparam logic [Width-1:0] CntMax = {Width{1'b1}};

  logic             sync0;
  logic             sync1;
  logic [Width-1:0] cnt;
  logic             out_q;
  logic             rise_q;
  logic             fall_q;

  // Decision signals for the current edge. The output only ever moves when
  // the synchronized level has disagreed with it for a full window, and the
  // window only advances on enabled cycles.
  logic differs;
  logic window_done;
  logic update;

  assign differs     = (sync1 != out_q);
  assign window_done = (cnt == CntMax);
  assign update      = differs && Enable && window_done;

  // Two-flop synchronizer. The first flop may go metastable on an
  // asynchronous edge of In; only the second flop's value is used downstream.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= In;
      sync1 <= sync0;
    end
  end

  // Stability counter. Agreement between the synchronized input and the
  // output clears the window so any bounce starts the count over. With
  // Enable low the count freezes rather than clearing, so a slow enable tick
  // simply stretches the window. The counter is cleared at its maximum when
  // the output updates and therefore never wraps.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt <= '0;
    end else if (!differs) begin
      cnt <= '0;
    end else if (Enable) begin
      if (window_done) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Debounced output plus its edge pulses. The pulses are registered on the
  // same edge that moves the output, so they are high exactly in the first
  // cycle the new level is visible and low on every other edge. Reset clears
  // them without producing a Fall, since it is not a debounced transition.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= update && !out_q &&  sync1;
      fall_q <= update &&  out_q && !sync1;
      if (update) begin
        out_q <= sync1;
      end
    end
  end

  assign Out  = out_q;
  assign Rise = rise_q;
  assign Fall = fall_q;

endmodule

// File: tb/tb_debouncer.sv
// ---------------------------------------------------------------------------
// tb_debouncer
//
// Purpose:
//   Self-checking bench for debouncer with Width=4 (16-cycle window).
//   A behavioural model tracks the synchronizer delay as a two-deep history
//   of In and counts enabled cycles of disagreement; a compare process checks
//   Out/Rise/Fall against it every cycle. Directed scenarios pin the model
//   with hand-computed edge counts, then a randomized phase exercises bounce,
//   enable gating and occasional resets.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_debouncer;

  localparam int W      = 4;
  localparam int Window = 1 << W;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  logic in_raw;
  logic out_w;
  logic rise_w;
  logic fall_w;

  int checks = 0;
  int errors = 0;

  // Model state: in_hist[0] is the most recently sampled In, in_hist[1] the
  // one before it, which is the level the debouncer is currently judging.
  int in_hist[2];
  int m_out;
  int m_run;
  int m_rise;
  int m_fall;
  bit model_valid = 1'b0;

  always #5 clock = ~clock;

  debouncer #(.Width(W)) dut (
    .Clock (clock),
    .Reset (reset),
    .Enable(enable),
    .In    (in_raw),
    .Out   (out_w),
    .Rise  (rise_w),
    .Fall  (fall_w)
  );

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic i);
    reset  = r;
    enable = e;
    in_raw = i;
  endtask

  // Behavioural model: the output adopts the delayed input once it has
  // disagreed for Window enabled cycles in a row; agreement restarts the run.
  always @(posedge clock) begin
    int s;
    if (reset === 1'b1) begin
      in_hist[0]  = 0;
      in_hist[1]  = 0;
      m_out       = 0;
      m_run       = 0;
      m_rise      = 0;
      m_fall      = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      s          = in_hist[1];
      in_hist[1] = in_hist[0];
      in_hist[0] = (in_raw === 1'b1) ? 1 : 0;
      m_rise     = 0;
      m_fall     = 0;
      if (s == m_out) begin
        m_run = 0;
      end else if (enable === 1'b1) begin
        m_run++;
        if (m_run == Window) begin
          m_rise = s;
          m_fall = 1 - s;
          m_out  = s;
          m_run  = 0;
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clock) begin
    if (model_valid) begin
      checkOutput("out_vs_model",  out_w,  m_out[0]);
      checkOutput("rise_vs_model", rise_w, m_rise[0]);
      checkOutput("fall_vs_model", fall_w, m_fall[0]);
      checkOutput("rise_fall_exclusive", rise_w & fall_w, 1'b0);
    end
  end

  task automatic doReset(input int cycles);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (cycles) @(negedge clock);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clock);
  endtask

  initial begin
    int seen;
    int rise_count;
    int run_len;
    logic level;

    applyStimulus(1'b1, 1'b1, 1'b0);
    @(negedge clock);
    doReset(3);
    checkOutput("reset_out",  out_w,  1'b0);
    checkOutput("reset_rise", rise_w, 1'b0);
    checkOutput("reset_fall", fall_w, 1'b0);

    // In 0->1: sampled on edge 1, Out rises on edge 18.
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clock);
      checkOutput("latency_out_low",  out_w,  1'b0);
      checkOutput("latency_rise_low", rise_w, 1'b0);
    end
    @(negedge clock);
    checkOutput("edge18_out",  out_w,  1'b1);
    checkOutput("edge18_rise", rise_w, 1'b1);
    @(negedge clock);
    checkOutput("edge19_rise", rise_w, 1'b0);
    checkOutput("edge19_out",  out_w,  1'b1);

    // Release: Fall pulses once, 18 edges after In drops.
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clock);
      checkOutput("release_out_high", out_w,  1'b1);
      checkOutput("release_fall_low", fall_w, 1'b0);
    end
    @(negedge clock);
    checkOutput("release_out",  out_w,  1'b0);
    checkOutput("release_fall", fall_w, 1'b1);
    @(negedge clock);
    checkOutput("release_fall_once", fall_w, 1'b0);

    // Glitch: 10 cycles high never reaches Out.
    rise_count = 0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (10) begin
      @(negedge clock);
      rise_count += int'(rise_w) + int'(fall_w);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (30) begin
      @(negedge clock);
      rise_count += int'(rise_w) + int'(fall_w);
    end
    checkOutput("glitch_out", out_w, 1'b0);
    checkCount("glitch_pulses", rise_count, 0);

    // Bounce every 3 cycles (ending low), then hold high: rise on edge 18.
    for (int c = 0; c < 34; c++) begin
      applyStimulus(1'b0, 1'b1, (c % 2 == 0) ? 1'b1 : 1'b0);
      repeat (3) @(negedge clock);
    end
    checkOutput("bounce_out", out_w, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    seen = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (out_w === 1'b1) begin
        seen = k;
        break;
      end
    end
    checkCount("bounce_hold_latency", seen, 18);

    // Enable 1 in 4: 16th enabled edge with the new level is edge 64.
    doReset(2);
    for (int c = 1; c <= 66; c++) begin
      applyStimulus(1'b0, (c % 4 == 0) ? 1'b1 : 1'b0, 1'b1);
      @(negedge clock);
      if (c == 63) checkOutput("gated_edge63_out", out_w, 1'b0);
      if (c == 64) begin
        checkOutput("gated_edge64_out",  out_w,  1'b1);
        checkOutput("gated_edge64_rise", rise_w, 1'b1);
      end
    end

    // Enable held low freezes Out.
    doReset(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (100) @(negedge clock);
    checkOutput("enable_low_out", out_w, 1'b0);

    // Reset mid-count (cnt reaches 10 after edge 12), then full latency.
    doReset(2);
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (12) @(negedge clock);
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(negedge clock);
    checkOutput("midcount_reset_out", out_w, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (17) @(negedge clock);
    checkOutput("midcount_edge17_out", out_w, 1'b0);
    @(negedge clock);
    checkOutput("midcount_edge18_out",  out_w,  1'b1);
    checkOutput("midcount_edge18_rise", rise_w, 1'b1);
    repeat (3) @(negedge clock);

    // Reset while Out=1: clears without a Fall pulse.
    applyStimulus(1'b1, 1'b1, 1'b0);
    @(negedge clock);
    checkOutput("reset_high_out",  out_w,  1'b0);
    checkOutput("reset_high_rise", rise_w, 1'b0);
    checkOutput("reset_high_fall", fall_w, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge clock);
    checkOutput("post_reset_fall", fall_w, 1'b0);

    // Randomized phase: runs of random length, mostly-on enable, rare resets.
    level = 1'b0;
    run_len = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run_len == 0) begin
        level   = ~level;
        run_len = $urandom_range(1, 40);
      end
      run_len--;
      applyStimulus(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
                    level);
      @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
